// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x-oversampled UART receiver.
package uart_pkg;

    localparam int OVERSAMPLE        = 16;
    localparam int SAMPLE_MID        = 7;
    localparam int DATA_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Value the parity bit must carry for the given data word.
    function automatic logic parity_expect(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling, 5..8 data bits, optional parity, one-deep
// output register with valid/ready handshake and overrun reporting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_16x,
    input  logic                 rxd,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_MID  = 4'(SAMPLE_MID);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    logic rxd_s;

    rx_state_e            state_q, state_d;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;

    uart_rx_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (rxd),
        .q_o  (rxd_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            done_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            done_q       <= done_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Frame FSM: every action is gated by the oversampling tick.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        done_d     = 1'b0;
        if (tick_16x) begin
            case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        if (!rxd_s) begin
                            state_d    = DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                            par_en_d   = parity_en;
                            par_odd_d  = parity_odd;
                            perr_d     = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
                DATA: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == TICK_LAST) begin
                        shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = par_en_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == TICK_LAST) begin
                        perr_d  = (rxd_s != parity_expect(8'(shift_q), par_odd_q));
                        state_d = STOP;
                    end
                end
                STOP: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == TICK_LAST) begin
                        ferr_d  = !rxd_s;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A completed frame loads if the slot is empty or being accepted this clk.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;
        if (done_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                frame_err_d  = ferr_q;
                parity_err_d = perr_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a frame-level timing model and per-cycle compare.
module tb_uart_rx;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       tick_16x   = 1'b0;
    logic       rxd        = 1'b1;
    logic       parity_en  = 1'b0;
    logic       parity_odd = 1'b0;
    logic       rx_ready   = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    uart_rx #(.DATA_BITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_16x  (tick_16x),
        .rxd       (rxd),
        .parity_en (parity_en),
        .parity_odd(parity_odd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         vedge;
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t       pending[$];
    int         edge_idx   = 0;
    int         ready_mode = 0;
    bit         cmp_on     = 1'b0;
    int         total      = 0;
    int         bad        = 0;
    int         over_cnt   = 0;
    logic       m_valid    = 1'b0;
    logic [7:0] m_data     = 8'h00;
    logic       m_ferr     = 1'b0;
    logic       m_perr     = 1'b0;
    logic       m_over     = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: words appear at their predicted edge; handshake applied per edge.
    always @(posedge clk) begin
        edge_idx++;
        if (!rst_n) begin
            m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_perr = 1'b0; m_over = 1'b0;
            pending.delete();
        end else begin
            m_over = 1'b0;
            if (pending.size() > 0 && pending[0].vedge == edge_idx) begin
                if (!m_valid || rx_ready) begin
                    m_valid = 1'b1;
                    m_data  = pending[0].data;
                    m_ferr  = pending[0].ferr;
                    m_perr  = pending[0].perr;
                end else begin
                    m_over = 1'b1;
                end
                void'(pending.pop_front());
            end else if (m_valid && rx_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Tick on every 4th edge; ready pattern chosen by ready_mode.
    always @(negedge clk) begin
        tick_16x = ((edge_idx + 1) % 4 == 0);
        case (ready_mode)
            0:       rx_ready = 1'b0;
            1:       rx_ready = 1'b1;
            default: rx_ready = (pending.size() > 0 && pending[0].vedge == edge_idx + 1);
        endcase
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_valid", rx_valid, m_valid);
            chk("cyc_overrun", overrun, m_over);
            if (m_valid) begin
                chk("cyc_data", rx_data, m_data);
                chk("cyc_frame_err", frame_err, m_ferr);
                chk("cyc_parity_err", parity_err, m_perr);
            end
            if (overrun === 1'b1) over_cnt++;
        end
    end

    // Drive one frame; predict the edge at which the word must appear.
    task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stopbit);
        int   fall;
        int   d;
        int   nb;
        exp_t e;
        @(negedge clk);
        rxd  = 1'b0;
        fall = edge_idx;
        d    = fall + 3;
        while (d % 4 != 0) d++;
        nb      = 8 + (parity_en ? 1 : 0) + 1;
        e.vedge = d + 4 * (8 + 16 * nb) + 1;
        e.data  = data;
        e.ferr  = !stopbit;
        e.perr  = parity_en && (pbit != ((^data) ^ parity_odd));
        pending.push_back(e);
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (64) @(negedge clk);
        end
        if (parity_en) begin
            rxd = pbit;
            repeat (64) @(negedge clk);
        end
        rxd = stopbit;
        repeat (64) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic expect_word(input string name, input logic [7:0] data,
                               input logic ferr, input logic perr);
        #1;
        chk({name, "_valid"}, rx_valid, 1'b1);
        chk({name, "_data"}, rx_data, data);
        chk({name, "_frame_err"}, frame_err, ferr);
        chk({name, "_parity_err"}, parity_err, perr);
        chk({name, "_model_data"}, m_data, data);
    endtask

    task automatic consume(input string name);
        ready_mode = 1;
        repeat (3) @(negedge clk);
        #1;
        ready_mode = 0;
        chk({name, "_consumed"}, rx_valid, 1'b0);
    endtask

    initial begin
        int         base;
        logic [7:0] abort_word;
        abort_word = 8'h96;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_valid", rx_valid, 1'b0);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_flags", {frame_err, parity_err, overrun}, 3'b000);
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;
        cmp_on = 1'b1;
        repeat (10) @(negedge clk);

        send_frame(8'hA5, 1'b0, 1'b1);
        expect_word("a5", 8'hA5, 1'b0, 1'b0);
        consume("a5");

        @(negedge clk);
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        #1 chk("false_start_no_valid", rx_valid, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1);
        expect_word("3c", 8'h3C, 1'b0, 1'b0);
        consume("3c");

        #1; parity_en = 1'b1; parity_odd = 1'b0;
        send_frame(8'h37, 1'b0, 1'b1);
        expect_word("even_bad", 8'h37, 1'b0, 1'b1);
        consume("even_bad");
        send_frame(8'h37, 1'b1, 1'b1);
        expect_word("even_ok", 8'h37, 1'b0, 1'b0);
        consume("even_ok");
        #1; parity_odd = 1'b1;
        send_frame(8'h37, 1'b0, 1'b1);
        expect_word("odd_ok", 8'h37, 1'b0, 1'b0);
        consume("odd_ok");

        #1; parity_en = 1'b0; parity_odd = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0);
        expect_word("stop_err", 8'h55, 1'b1, 1'b0);
        consume("stop_err");
        repeat (200) @(negedge clk);

        base = over_cnt;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        expect_word("overrun_keep", 8'h11, 1'b0, 1'b0);
        chk("overrun_pulses", over_cnt - base, 1);
        ready_mode = 2;
        send_frame(8'h33, 1'b0, 1'b1);
        expect_word("accept_load", 8'h33, 1'b0, 1'b0);
        chk("accept_no_overrun", over_cnt - base, 1);
        consume("accept_load");

        send_frame(8'h5A, 1'b0, 1'b1);
        expect_word("pre_reset", 8'h5A, 1'b0, 1'b0);
        @(negedge clk);
        rxd = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = abort_word[i];
            repeat (64) @(negedge clk);
        end
        rxd = abort_word[3];
        repeat (32) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midreset_valid", rx_valid, 1'b0);
        chk("midreset_data", rx_data, 8'h00);
        chk("midreset_flags", {frame_err, parity_err, overrun}, 3'b000);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (300) @(negedge clk);
        #1 chk("abort_no_output", rx_valid, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1);
        expect_word("f0", 8'hF0, 1'b0, 1'b0);
        consume("f0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: run still active at t=%0t, required finished", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, giving data bits per frame; legal values are 5 to 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port tick_16x, input, 1 bit: one-clk pulse at 16x the baud rate, from the baud generator.
REQ-005 SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port parity_en, input, 1 bit: a parity bit follows the data when 1.
REQ-007 SHALL have port parity_odd, input, 1 bit: 1 selects odd parity, 0 selects even.
REQ-008 SHALL have port rx_data, output, DATA_BITS bits: received word, LSB first on the line.
REQ-009 SHALL have port rx_valid, output, 1 bit: rx_data and the error flags hold a valid word.
REQ-010 SHALL have port rx_ready, input, 1 bit: the consumer accepts the word.
REQ-011 SHALL have port frame_err, output, 1 bit: stop bit sampled low; valid while rx_valid=1.
REQ-012 SHALL have port parity_err, output, 1 bit: parity mismatch; valid while rx_valid=1.
REQ-013 SHALL have port overrun, output, 1 bit: one-clk pulse when a completed frame is dropped.

Function
REQ-014 SHALL pass rxd through a 2-flop synchronizer before any use.
REQ-015 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-016 SHALL advance the 4-bit tick counter and every state action only on clk edges where tick_16x=1; with tick_16x held low, all state SHALL hold.
REQ-017 IDLE: a synchronized rxd low on a tick SHALL move to START and clear the tick counter.
REQ-018 START: at tick count 7 (mid-bit), rxd still low SHALL move to DATA with the counter cleared; rxd high SHALL be a false start and return to IDLE without output.
REQ-019 DATA: each 16th tick SHALL sample rxd into the shift register LSB first; after DATA_BITS samples, move to PARITY if parity_en=1, else to STOP.
REQ-020 PARITY: the 16th-tick sample SHALL be checked against the XOR of the data bits, inverted when parity_odd=1; a mismatch sets the internal parity error.
REQ-021 STOP: the 16th-tick sample SHALL set the internal frame error if low; the FSM SHALL then return to IDLE on that same tick so back-to-back frames are received.
REQ-022 parity_en and parity_odd SHALL be sampled on leaving START and held for the rest of the frame.
REQ-023 One clk after the stop sample, the output register SHALL load rx_data, frame_err and parity_err and set rx_valid=1.
REQ-024 rx_valid, rx_data and the flags SHALL stay stable until a clk with rx_valid=1 and rx_ready=1; that clk SHALL clear rx_valid.
REQ-025 Frame completes while rx_valid=1 and rx_ready=0: the new word SHALL be discarded, the old word kept, and overrun pulsed for 1 clk.
REQ-026 Frame completes in the same clk as an accept: the new word SHALL load, rx_valid SHALL stay 1, and no overrun SHALL occur.
REQ-027 A frame with a stop error SHALL still be delivered with frame_err=1; no break handling is required.

Reset
REQ-028 rst_n low SHALL immediately force: FSM to IDLE, counters to 0, both synchronizer flops to 1, rx_data to 0, and rx_valid, frame_err, parity_err and overrun to 0.
REQ-029 A reset during any frame SHALL abort it without output; reception SHALL resume at the next falling edge after release.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum, OVERSAMPLE=16, SAMPLE_MID=7 and the DATA_BITS default.
REQ-031 The synchronizer SHALL be a sub-module, uart_rx_sync, parameterized by reset value (1 here).

Verification
REQ-032 tick_16x every 4 clk, 8N1, send 0xA5 -> rx_valid=1 one clk after the stop sample, rx_data=0xA5, both error flags 0.
REQ-033 rxd low for 4 ticks then high -> no rx_valid, FSM back in IDLE, next frame 0x3C received correctly.
REQ-034 parity_en=1, parity_odd=0, send 0x37 with parity bit 0 -> rx_data=0x37, parity_err=1; repeat with parity bit 1 -> parity_err=0.
REQ-035 send 0x55 with stop bit 0 -> rx_data=0x55, frame_err=1.
REQ-036 rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_data stays 0x11, overrun pulses once; then rx_ready=1 in the clk the 0x33 frame completes -> rx_data=0x33, no overrun.
REQ-037 assert rst_n=0 in the 4th data bit -> all outputs 0 at once; after release, 0xF0 received cleanly.
